// File: rtl/rr_mem_arbiter_if.sv
// rr_mem_if: per-core request/response lanes plus the shared memory port
interface rr_mem_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [NUM_CORES-1:0] req, rw, gnt, done, err;
  logic [NUM_CORES*ADDR_W-1:0] addr_in;
  logic [NUM_CORES*DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_valid, mem_rw, mem_ack;
  modport slave (
    input req, rw, addr_in, wdata_in, mem_rdata, mem_ack,
    output gnt, done, err, rdata, mem_valid, mem_rw, mem_addr, mem_wdata
  );
  modport master (
    output req, rw, addr_in, wdata_in, mem_rdata, mem_ack,
    input gnt, done, err, rdata, mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin arbiter sharing one memory port among NUM_CORES cores
module rr_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  rr_mem_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] last, last_n, sel, sel_n, win, idx;
  logic [7:0] cnt, cnt_n;
  logic abort, abort_n, valid_n, rw_n;
  logic [NUM_CORES-1:0] gnt_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  // descending scan so the core right after last is written last and wins
  always_comb begin
    win = last;
    idx = '0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_CORES);
      if (bus.req[idx]) win = idx;
    end
  end
  always_comb begin
    state_n = state;
    last_n = last;
    sel_n = sel;
    cnt_n = cnt;
    abort_n = abort;
    gnt_n = bus.gnt;
    done_n = '0;
    err_n = '0;
    rdata_n = bus.rdata;
    valid_n = bus.mem_valid;
    rw_n = bus.mem_rw;
    addr_n = bus.mem_addr;
    wdata_n = bus.mem_wdata;
    case (state)
      IDLE: if (|bus.req) begin
        state_n = ACCESS;
        sel_n = win;
        gnt_n = '0;
        gnt_n[win] = 1'b1;
        valid_n = 1'b1;
        rw_n = bus.rw[win];
        addr_n = bus.addr_in[int'(win)*ADDR_W +: ADDR_W];
        wdata_n = bus.wdata_in[int'(win)*DATA_W +: DATA_W];
        cnt_n = '0;
        abort_n = 1'b0;
      end
      ACCESS: if (bus.mem_ack || cnt == 8'(TIMEOUT - 1)) begin
        state_n = RESP;
        gnt_n = '0;
        valid_n = 1'b0;
        abort_n = !bus.mem_ack;
        rdata_n = (bus.mem_ack && !bus.mem_rw) ? bus.mem_rdata : bus.rdata;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      RESP: begin
        state_n = IDLE;
        last_n = sel;
        done_n[sel] = 1'b1;
        err_n[sel] = abort;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= IW'(NUM_CORES - 1);
      sel <= '0;
      cnt <= '0;
      abort <= 1'b0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.err <= '0;
      bus.rdata <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_rw <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      sel <= sel_n;
      cnt <= cnt_n;
      abort <= abort_n;
      bus.gnt <= gnt_n;
      bus.done <= done_n;
      bus.err <= err_n;
      bus.rdata <= rdata_n;
      bus.mem_valid <= valid_n;
      bus.mem_rw <= rw_n;
      bus.mem_addr <= addr_n;
      bus.mem_wdata <= wdata_n;
    end
  end
endmodule

// File: doc/rr_mem_arbiter.md
RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, number of requesting cores, legal range 2..8.
REQ-002 The block SHALL have parameter ADDR_W, default 12, address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, data width.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles before abort, legal range 2..255.
REQ-005 The block SHALL run on one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, the reset, asynchronous and active-high.
REQ-008 The block SHALL have port req, input, NUM_CORES bits, per-core access request.
REQ-009 The block SHALL have port rw, input, NUM_CORES bits, per-core direction, 1 = write and 0 = read.
REQ-010 The block SHALL have port addr_in, input, NUM_CORES*ADDR_W bits, per-core address, with core i at bits [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port wdata_in, input, NUM_CORES*DATA_W bits, per-core write data, packed the same way as addr_in.
REQ-012 The block SHALL have port gnt, output, NUM_CORES bits, one-hot grant.
REQ-013 The block SHALL have port done, output, NUM_CORES bits, per-core completion pulse.
REQ-014 The block SHALL have port err, output, NUM_CORES bits, per-core timeout pulse, coincident with done.
REQ-015 The block SHALL have port rdata, output, DATA_W bits, read data returned to the granted core.
REQ-016 The block SHALL have port mem_valid, output, 1 bit, memory request valid.
REQ-017 The block SHALL have port mem_rw, output, 1 bit, memory direction, 1 = write.
REQ-018 The block SHALL have port mem_addr, output, ADDR_W bits, memory address.
REQ-019 The block SHALL have port mem_wdata, output, DATA_W bits, memory write data.
REQ-020 The block SHALL have port mem_rdata, input, DATA_W bits, memory read data.
REQ-021 The block SHALL have port mem_ack, input, 1 bit, memory completion.

Function
REQ-022 The block SHALL implement a state machine with states IDLE, ACCESS and RESP, all outputs registered.
REQ-023 In IDLE with req non-zero, the block SHALL select the winner w on the rising edge by round robin, scanning from index (last+1) mod NUM_CORES upward with wrap-around.
REQ-024 On selecting w, the block SHALL latch rw[w], addr_in slice w and wdata_in slice w, assert gnt[w], and enter ACCESS.
REQ-025 In ACCESS, the block SHALL drive mem_valid=1 and mem_rw/mem_addr/mem_wdata from the latched values, stable until exit.
REQ-026 On mem_ack=1 in ACCESS, the block SHALL capture mem_rdata into rdata for a read, leave rdata unchanged for a write, and enter RESP.
REQ-027 In ACCESS, a cycle counter SHALL start at 0 on entry and increment each cycle without mem_ack.
REQ-028 When the counter reaches TIMEOUT-1 without mem_ack, the block SHALL enter RESP with abort flagged and rdata unchanged.
REQ-029 If mem_ack and the timeout coincide, mem_ack SHALL win and no abort SHALL be flagged.
REQ-030 RESP SHALL last exactly one cycle: done[w]=1, err[w]=abort, gnt=0, mem_valid=0, last updated to w, next state IDLE.
REQ-031 Minimum latency SHALL be: req sampled at edge 0, gnt and mem_valid from edge 0, mem_ack seen at edge 1, done high after edge 2 for one cycle.
REQ-032 rdata SHALL hold its value until the next read completes.
REQ-033 A requester SHALL hold req until done; deasserting req after grant SHALL NOT cancel the transaction.
REQ-034 req SHALL be ignored in ACCESS and RESP, and new arbitration SHALL occur only in IDLE.
REQ-035 mem_ack SHALL be ignored outside ACCESS.
REQ-036 gnt SHALL be one-hot or zero at all times.
REQ-037 done and err SHALL never be asserted for a core other than w.
REQ-038 A core re-requesting immediately after done SHALL lose to any other requesting core.

Reset
REQ-039 While rst=1, asynchronously, the block SHALL set the state to IDLE, last to NUM_CORES-1 (core 0 has first priority), and gnt, done, err, mem_valid, mem_rw, mem_addr, mem_wdata, rdata and the counter all to 0.
REQ-040 Reset during ACCESS or RESP SHALL abort the transaction with no done pulse.
REQ-041 The first arbitration after reset SHALL occur on the first rising edge with rst=0.

Verification
REQ-042 Reset, then req=4'b1111 held, mem_ack=1 always -> grants in order core 0,1,2,3,0, each done 3 cycles apart.
REQ-043 Core 2 reads addr 12'h0A5, memory acks on the 3rd ACCESS cycle with 8'h3C -> rdata=8'h3C and done[2] one cycle after mem_ack.
REQ-044 Core 1 writes 8'h77 to 12'h010 -> mem_rw=1, mem_addr=12'h010, mem_wdata=8'h77 stable until ack; rdata unchanged.
REQ-045 mem_ack never asserted, TIMEOUT=16 -> mem_valid high 16 cycles, then done[w]=err[w]=1 for one cycle; ack on cycle 16 -> no err.
REQ-046 rst asserted mid-ACCESS -> all outputs 0 immediately, no done; after release, req=4'b1000 grants core 3.
REQ-047 Core 0 completes and re-requests alongside core 3 -> core 3 is granted next.
